// File: rtl/secuenciador_ciclo.sv
// rtl/secuenciador_ciclo.sv - drum cycle sequencer: turns a service grant into timed fill/wash/drain/rinse/spin/dry phases
module secuenciador_ciclo #(
    parameter int CW      = 8,
    parameter int T_FILL  = 20,
    parameter int T_WASH  = 40,
    parameter int T_DRAIN = 10,
    parameter int T_RINSE = 20,
    parameter int T_SPIN  = 15,
    parameter int T_DRY   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_secado,
    input  logic       start_lavado,
    input  logic       start_lavado_pesado,
    input  logic       door_closed,
    input  logic       stop,
    output logic       busy,
    output logic       door_lock,
    output logic       valve_in,
    output logic       pump_out,
    output logic       motor,
    output logic       motor_fast,
    output logic       heater,
    output logic [2:0] phase,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_DRAIN = 3'd3,
        S_RINSE = 3'd4,
        S_SPIN  = 3'd5,
        S_DRY   = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    localparam longint MAXV = (64'd1 << CW) - 64'd1;

    // Load value is T-1, clamped to all-ones when the timer is too narrow.
    function automatic logic [CW-1:0] sat_load(input int t);
        longint tm1;
        tm1 = longint'(t) - 64'd1;
        if (tm1 > MAXV)
            return '1;
        else
            return CW'(tm1);
    endfunction

    localparam logic [CW-1:0] L_FILL  = sat_load(T_FILL);
    localparam logic [CW-1:0] L_WASH  = sat_load(T_WASH);
    localparam logic [CW-1:0] L_WASH2 = sat_load(2 * T_WASH);
    localparam logic [CW-1:0] L_DRAIN = sat_load(T_DRAIN);
    localparam logic [CW-1:0] L_RINSE = sat_load(T_RINSE);
    localparam logic [CW-1:0] L_SPIN  = sat_load(T_SPIN);
    localparam logic [CW-1:0] L_DRY   = sat_load(T_DRY);

    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          pesado_q, pesado_d;
    logic          rinse_q, rinse_d;
    logic          abort_q, abort_d;

    logic busy_q, busy_d;
    logic door_lock_q, door_lock_d;
    logic valve_in_q, valve_in_d;
    logic pump_out_q, pump_out_d;
    logic motor_q, motor_d;
    logic motor_fast_q, motor_fast_d;
    logic heater_q, heater_d;
    logic done_q, done_d;
    logic error_q, error_d;

    logic any_start;
    logic reject;
    logic expired;

    always_comb begin
        state_d   = state_q;
        timer_d   = (timer_q == '0) ? '0 : timer_q - 1'b1;
        pesado_d  = pesado_q;
        rinse_d   = rinse_q;
        abort_d   = abort_q;
        reject    = 1'b0;
        done_d    = 1'b0;
        any_start = start_lavado_pesado | start_lavado | start_secado;
        expired   = (timer_q == '0);

        case (state_q)
            S_IDLE: begin
                pesado_d = 1'b0;
                rinse_d  = 1'b0;
                abort_d  = 1'b0;
                timer_d  = '0;
                if (any_start) begin
                    if (!door_closed) begin
                        reject = 1'b1;
                    end else if (start_lavado_pesado) begin
                        state_d  = S_FILL;
                        pesado_d = 1'b1;
                    end else if (start_lavado) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_DRY;
                    end
                end
            end
            S_FAULT: begin
                if (stop && door_closed)
                    state_d = S_IDLE;
            end
            default: begin
                // Door-open beats stop, which beats timer expiry.
                if (!door_closed) begin
                    state_d = S_FAULT;
                end else if (stop && (state_q == S_FILL || state_q == S_WASH ||
                                      state_q == S_RINSE)) begin
                    state_d = S_DRAIN;
                    rinse_d = 1'b0;
                    abort_d = 1'b1;
                end else if (stop && (state_q == S_DRY || state_q == S_SPIN)) begin
                    state_d = S_IDLE;
                end else begin
                    if (stop && state_q == S_DRAIN)
                        abort_d = 1'b1;
                    if (expired) begin
                        case (state_q)
                            S_FILL:  state_d = rinse_q ? S_RINSE : S_WASH;
                            S_WASH:  state_d = S_DRAIN;
                            S_RINSE: state_d = S_DRAIN;
                            S_DRAIN: begin
                                if (abort_q || stop) begin
                                    state_d = S_IDLE;
                                end else if (rinse_q) begin
                                    state_d = S_SPIN;
                                    rinse_d = 1'b0;
                                end else if (pesado_q) begin
                                    state_d = S_FILL;
                                    rinse_d = 1'b1;
                                end else begin
                                    state_d = S_SPIN;
                                end
                            end
                            S_SPIN, S_DRY: begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                            default: state_d = S_FAULT;
                        endcase
                    end
                end
            end
        endcase

        if (state_d != state_q) begin
            case (state_d)
                S_FILL:  timer_d = L_FILL;
                S_WASH:  timer_d = pesado_d ? L_WASH2 : L_WASH;
                S_DRAIN: timer_d = L_DRAIN;
                S_RINSE: timer_d = L_RINSE;
                S_SPIN:  timer_d = L_SPIN;
                S_DRY:   timer_d = L_DRY;
                default: timer_d = '0;
            endcase
        end

        // Actuators follow the state being entered so they line up with phase.
        busy_d       = (state_d != S_IDLE);
        door_lock_d  = (state_d != S_IDLE);
        valve_in_d   = (state_d == S_FILL);
        pump_out_d   = (state_d == S_DRAIN) || (state_d == S_SPIN) || (state_d == S_FAULT);
        motor_d      = (state_d == S_WASH) || (state_d == S_RINSE) || (state_d == S_DRY);
        motor_fast_d = (state_d == S_SPIN);
        heater_d     = (state_d == S_DRY) || ((state_d == S_WASH) && pesado_d);
        error_d      = reject || (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            pesado_q     <= 1'b0;
            rinse_q      <= 1'b0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
            door_lock_q  <= 1'b0;
            valve_in_q   <= 1'b0;
            pump_out_q   <= 1'b0;
            motor_q      <= 1'b0;
            motor_fast_q <= 1'b0;
            heater_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pesado_q     <= pesado_d;
            rinse_q      <= rinse_d;
            abort_q      <= abort_d;
            busy_q       <= busy_d;
            door_lock_q  <= door_lock_d;
            valve_in_q   <= valve_in_d;
            pump_out_q   <= pump_out_d;
            motor_q      <= motor_d;
            motor_fast_q <= motor_fast_d;
            heater_q     <= heater_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign busy       = busy_q;
    assign door_lock  = door_lock_q;
    assign valve_in   = valve_in_q;
    assign pump_out   = pump_out_q;
    assign motor      = motor_q;
    assign motor_fast = motor_fast_q;
    assign heater     = heater_q;
    assign phase      = state_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
